// File: rtl/config_loader_if.sv
// Stream-in / memory-mapped-write-out bundle for the configuration loader.
// The master side feeds packet words and observes the write bus; the slave
// side is the loader itself.
interface config_loader_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int WORD_WIDTH = 36
);
    logic [WORD_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [ADDR_WIDTH-1:0] config_addr;
    logic [WORD_WIDTH-1:0] config_data;
    logic                  config_write;
    logic                  busy;
    logic                  done;

    modport master (
        output in_data, in_valid,
        input  in_ready, config_addr, config_data, config_write, busy, done
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, config_addr, config_data, config_write, busy, done
    );
endinterface

// File: rtl/config_loader.sv
// Configuration loader: parses a word stream of packets
// (header = base address, count = N, then N data words) and replays the data
// words as memory-mapped writes at base, base+1, ... with optional idle gaps
// between consecutive writes. The write bus parks on IDLE_ADDR when not writing.
module config_loader #(
    parameter int          ADDR_WIDTH  = 10,
    parameter int          WORD_WIDTH  = 36,
    parameter int          COUNT_WIDTH = 10,
    parameter int unsigned IDLE_ADDR   = 0,
    parameter int          WRITE_GAP   = 0
) (
    input logic           clock,
    input logic           clear,
    config_loader_if.slave bus
);

    typedef enum logic [1:0] {
        HEADER,
        COUNT,
        DATA,
        GAP
    } state_t;

    // The gap counter holds WRITE_GAP-1 down to 0, so it needs just enough bits for that.
    localparam int GAP_W = (WRITE_GAP > 1) ? $clog2(WRITE_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'((WRITE_GAP > 0) ? (WRITE_GAP - 1) : 0);
    localparam logic [ADDR_WIDTH-1:0] IDLE_ADDR_C = ADDR_WIDTH'(IDLE_ADDR);

    state_t                 state;
    logic [ADDR_WIDTH-1:0]  write_addr;
    logic [COUNT_WIDTH-1:0] remaining;
    logic [GAP_W-1:0]       gap_cnt;

    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [WORD_WIDTH-1:0]  data_q;
    logic                   write_q;
    logic                   busy_q;
    logic                   done_q;

    logic                   ready_c;
    logic                   take;
    logic [COUNT_WIDTH-1:0] count_word;

    // Ready follows the state directly so the loader is receptive on the very
    // first cycle after clear releases; clear itself always blocks transfers.
    assign ready_c    = !clear && (state != GAP);
    assign take       = bus.in_valid && ready_c;
    assign count_word = bus.in_data[COUNT_WIDTH-1:0];

    assign bus.in_ready     = ready_c;
    assign bus.config_addr  = addr_q;
    assign bus.config_data  = data_q;
    assign bus.config_write = write_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;

    // Packet parser and write generator; every output is registered and
    // falls back to the parked idle value on any cycle without a write.
    always_ff @(posedge clock) begin
        if (clear) begin
            state      <= HEADER;
            write_addr <= '0;
            remaining  <= '0;
            gap_cnt    <= '0;
            addr_q     <= IDLE_ADDR_C;
            data_q     <= '0;
            write_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            write_q <= 1'b0;
            addr_q  <= IDLE_ADDR_C;
            data_q  <= '0;
            done_q  <= 1'b0;
            busy_q  <= busy_q && !done_q;

            case (state)
                HEADER: begin
                    if (take) begin
                        write_addr <= bus.in_data[ADDR_WIDTH-1:0];
                        busy_q     <= 1'b1;
                        state      <= COUNT;
                    end
                end
                COUNT: begin
                    if (take) begin
                        remaining <= count_word;
                        if (count_word == '0) begin
                            done_q <= 1'b1;
                            state  <= HEADER;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (take) begin
                        write_q    <= 1'b1;
                        addr_q     <= write_addr;
                        data_q     <= bus.in_data;
                        write_addr <= write_addr + ADDR_WIDTH'(1);
                        remaining  <= remaining - COUNT_WIDTH'(1);
                        if (remaining == COUNT_WIDTH'(1)) begin
                            done_q <= 1'b1;
                            state  <= HEADER;
                        end else if (WRITE_GAP > 0) begin
                            gap_cnt <= GAP_RELOAD;
                            state   <= GAP;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == '0) begin
                        state <= DATA;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
                default: state <= HEADER;
            endcase
        end
    end

endmodule

// File: doc/config_loader.md
CONFIG_LOADER -- requirements
Module: config_loader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, width of config_addr.
REQ-002 SHALL have parameter WORD_WIDTH, default 36, width of stream and config_data.
REQ-003 SHALL have parameter COUNT_WIDTH, default 10, width of packet word count.
REQ-004 SHALL have parameter IDLE_ADDR, default 0, parking address decoded by no memory-mapped target.
REQ-005 SHALL have parameter WRITE_GAP, default 0, idle cycles inserted between consecutive writes (0 = back-to-back).
REQ-006 SHALL have port clock  input  1  sole clock, rising edge.
REQ-007 SHALL have port clear  input  1  reset, synchronous, active-high.
REQ-008 SHALL have port in_data  input  WORD_WIDTH  packet stream word.
REQ-009 SHALL have port in_valid  input  1  in_data valid.
REQ-010 SHALL have port in_ready  output  1  loader accepts in_data this cycle.
REQ-011 SHALL have port config_addr  output  ADDR_WIDTH  memory-mapped write address.
REQ-012 SHALL have port config_data  output  WORD_WIDTH  memory-mapped write data.
REQ-013 SHALL have port config_write  output  1  high on cycles carrying a real write.
REQ-014 SHALL have port busy  output  1  packet in progress.
REQ-015 SHALL have port done  output  1  one-cycle pulse at packet completion.

Function
REQ-016 SHALL transfer a stream word only on a cycle with in_valid and in_ready both high.
REQ-017 SHALL parse packets as: header word (bits ADDR_WIDTH-1:0 = base address, upper bits ignored), count word (bits COUNT_WIDTH-1:0 = N, upper bits ignored), then N data words.
REQ-018 SHALL implement states HEADER, COUNT, DATA, GAP; HEADER->COUNT on header transfer; COUNT->DATA on count transfer with N>0; COUNT->HEADER on count transfer with N=0.
REQ-019 SHALL in DATA, on each transfer, register config_addr = base + i (i = 0..N-1), config_data = in_data, config_write = 1, all visible the cycle after the transfer.
REQ-020 SHALL compute base + i modulo 2^ADDR_WIDTH (address wraps silently).
REQ-021 SHALL after a data transfer go to GAP when WRITE_GAP>0 and the word was not the last, remain in DATA when WRITE_GAP=0 and not last, and go to HEADER after the last word.
REQ-022 SHALL hold GAP for exactly WRITE_GAP cycles with in_ready low, then return to DATA.
REQ-023 SHALL drive in_ready high in HEADER, COUNT, DATA and low in GAP.
REQ-024 SHALL on every cycle without a write drive config_addr = IDLE_ADDR, config_data = 0, config_write = 0.
REQ-025 SHALL drive busy high from the cycle after the header transfer until the cycle done is high, inclusive.
REQ-026 SHALL pulse done for one cycle: concurrent with the last write's outputs, or the cycle after the count transfer when N=0.
REQ-027 SHALL wait indefinitely in any state while in_valid is low; stalls within DATA insert IDLE_ADDR cycles, no loss or duplication.
REQ-028 SHALL accept a following header in the same cycle done is high (HEADER already active).

Reset
REQ-029 SHALL while clear is high force state HEADER, in_ready 0, config_addr IDLE_ADDR, config_data 0, config_write 0, busy 0, done 0, counters 0.
REQ-030 SHALL on clear mid-packet abandon the packet with no further writes; first cycle after clear deasserts is HEADER, in_ready 1.
REQ-031 SHALL give clear priority over any simultaneous stream transfer.

Verification
REQ-032 SHALL cover: WRITE_GAP=0, header 0x100, N=3, data A,B,C continuous -> writes (0x100,A),(0x101,B),(0x102,C) on consecutive cycles, done with third write.
REQ-033 SHALL cover: WRITE_GAP=2, N=2 -> two writes separated by exactly 2 IDLE_ADDR cycles, in_ready low during those 2 cycles.
REQ-034 SHALL cover: ADDR_WIDTH=10, header 0x3FF, N=2 -> writes at 0x3FF then 0x000.
REQ-035 SHALL cover: N=0 packet -> no config_write, done 1 cycle after count transfer, next header accepted immediately.
REQ-036 SHALL cover: clear asserted after second of 4 data words -> exactly 2 writes emitted, outputs at reset values, new packet then loads correctly.
REQ-037 SHALL cover: random in_valid gaps during DATA -> written sequence identical to gap-free run, config_write never high with config_addr = IDLE_ADDR unless base+i = IDLE_ADDR.
